// File: rtl/page_allocator_pkg.sv
// Shared constants and types for the packet-page allocator and its port arbiters.
package page_allocator_pkg;
  localparam int PORT_NUM  = 16;
  localparam int ADDR_W    = 11;
  localparam int PAGE_NUM  = 2048;
  localparam int REL_DEPTH = 8;
  localparam int PORT_W    = $clog2(PORT_NUM);
  localparam int REL_PTR_W = $clog2(REL_DEPTH);

  typedef logic [ADDR_W-1:0] page_addr_t;
  typedef logic [PORT_W-1:0] port_idx_t;
  typedef logic [ADDR_W:0]   page_cnt_t;
endpackage

// File: rtl/page_allocator_if.sv
// Allocation, release and free-page FIFO signals of the page allocator; slave = allocator side.
interface page_allocator_if;
  import page_allocator_pkg::*;

  logic [PORT_NUM-1:0] alloc_req;
  logic [PORT_NUM-1:0] alloc_gnt;
  page_addr_t          alloc_addr;
  logic                rel_valid;
  page_addr_t          rel_addr;
  logic                rel_ready;
  logic                pop_head;
  page_addr_t          head_addr;
  logic                push_tail;
  page_addr_t          tail_addr;
  page_cnt_t           free_cnt;
  logic                pool_low;

  modport slave (
    input  alloc_req, rel_valid, rel_addr, head_addr,
    output alloc_gnt, alloc_addr, rel_ready, pop_head, push_tail, tail_addr, free_cnt, pool_low
  );

  modport master (
    output alloc_req, rel_valid, rel_addr, head_addr,
    input  alloc_gnt, alloc_addr, rel_ready, pop_head, push_tail, tail_addr, free_cnt, pool_low
  );
endinterface

// File: rtl/page_allocator_rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant and index; pointer moves past the
// winner only when en is high. No backpressure of its own.
module rr_arbiter #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    // Scan starting at the priority pointer, wrapping modulo N.
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
    ptr_d = ptr_q;
    if (en && found) ptr_d = (int'(idx) == N-1) ? '0 : idx + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/page_allocator.sv
// Page-pool front end: arbitrated 1-cycle page grants from the free-page FIFO head, staged releases
// pushed back 1 cycle later; rel_ready drops only when staging is full. PAGE_ALLOC_STAT_EN adds min_free.
module page_allocator
  import page_allocator_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
`ifdef PAGE_ALLOC_STAT_EN
  input  logic            stat_clr,
  output page_cnt_t       min_free,
`endif
  page_allocator_if.slave pa
);
  logic [PORT_NUM-1:0] eligible, arb_gnt;
  port_idx_t           arb_idx;
  logic                grant_en, push_tail;
  logic [PORT_NUM-1:0] alloc_gnt_q, alloc_gnt_d;
  page_addr_t          alloc_addr_q, alloc_addr_d;
  page_cnt_t           free_cnt_q, free_cnt_d;
  page_addr_t          stg_mem_q [REL_DEPTH];
  page_addr_t          stg_mem_d [REL_DEPTH];
  logic [REL_PTR_W:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                stg_empty, stg_full;

  // A port granted last cycle is masked so a late-dropping requester is not granted twice.
  assign eligible = pa.alloc_req & ~alloc_gnt_q;
  // One page stays behind as the FIFO lookahead head, so at least two must be free to grant.
  assign grant_en = rst_n && (|eligible) && (free_cnt_q >= page_cnt_t'(2));

  rr_arbiter #(.N(PORT_NUM), .IDX_W(PORT_W)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (grant_en),
    .req   (eligible),
    .gnt   (arb_gnt),
    .idx   (arb_idx)
  );

  assign stg_empty = (wr_ptr_q == rd_ptr_q);
  assign stg_full  = (wr_ptr_q[REL_PTR_W] != rd_ptr_q[REL_PTR_W]) &&
                     (wr_ptr_q[REL_PTR_W-1:0] == rd_ptr_q[REL_PTR_W-1:0]);
  assign push_tail = !stg_empty;

  always_comb begin
    stg_mem_d = stg_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (pa.rel_valid && !stg_full) begin
      stg_mem_d[wr_ptr_q[REL_PTR_W-1:0]] = pa.rel_addr;
      wr_ptr_d = wr_ptr_q + (REL_PTR_W+1)'(1);
    end
    if (push_tail) rd_ptr_d = rd_ptr_q + (REL_PTR_W+1)'(1);

    free_cnt_d = free_cnt_q;
    if (push_tail && !grant_en)      free_cnt_d = free_cnt_q + page_cnt_t'(1);
    else if (!push_tail && grant_en) free_cnt_d = free_cnt_q - page_cnt_t'(1);

    alloc_gnt_d  = grant_en ? arb_gnt : '0;
    alloc_addr_d = grant_en ? pa.head_addr : alloc_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_gnt_q  <= '0;
      alloc_addr_q <= '0;
      free_cnt_q   <= page_cnt_t'(PAGE_NUM);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      stg_mem_q    <= '{default: '0};
    end else begin
      alloc_gnt_q  <= alloc_gnt_d;
      alloc_addr_q <= alloc_addr_d;
      free_cnt_q   <= free_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      stg_mem_q    <= stg_mem_d;
    end
  end

  assign pa.alloc_gnt  = alloc_gnt_q;
  assign pa.alloc_addr = alloc_addr_q;
  assign pa.pop_head   = grant_en;
  assign pa.push_tail  = push_tail;
  assign pa.tail_addr  = stg_empty ? '0 : stg_mem_q[rd_ptr_q[REL_PTR_W-1:0]];
  assign pa.rel_ready  = !stg_full;
  assign pa.free_cnt   = free_cnt_q;
  assign pa.pool_low   = (free_cnt_q < page_cnt_t'(2));

`ifdef PAGE_ALLOC_STAT_EN
  page_cnt_t min_free_q, min_free_d;

  always_comb begin
    min_free_d = min_free_q;
    if (stat_clr)                     min_free_d = free_cnt_q;
    else if (free_cnt_q < min_free_q) min_free_d = free_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) min_free_q <= page_cnt_t'(PAGE_NUM);
    else        min_free_q <= min_free_d;
  end

  assign min_free = min_free_q;
`endif

  // Count above the pool size means a page was released twice.
  a_no_double_free: assert property (@(posedge clk) disable iff (!rst_n)
    free_cnt_q <= page_cnt_t'(PAGE_NUM));
  a_gnt_matches_idx: assert property (@(posedge clk) disable iff (!rst_n)
    grant_en |-> (arb_gnt == (PORT_NUM'(1) << arb_idx)));
endmodule

// File: tb/tb_page_allocator.sv
// Bench for page_allocator: directed scenarios plus random traffic against a queue-based pool model.
module tb_page_allocator;
  import page_allocator_pkg::*;

  logic clk;
  logic rst_n;
  page_allocator_if pa();
`ifdef PAGE_ALLOC_STAT_EN
  logic      stat_clr;
  page_cnt_t min_free;
`endif

  page_allocator dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef PAGE_ALLOC_STAT_EN
    .stat_clr (stat_clr),
    .min_free (min_free),
`endif
    .pa       (pa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_bad;

  // Stimulus variables and reference model
  logic [PORT_NUM-1:0] req;
  logic                rel_v;
  page_addr_t          rel_a;
  int                  m_free, m_ptr, e_win;
  logic [PORT_NUM-1:0] m_gnt;
  page_addr_t          m_addr, e_tail;
  logic                e_pop, e_push, e_rdy;
  page_addr_t          stg[$];
  page_addr_t          pool[$];
  page_addr_t          alloc_q[$];

  task automatic model_reset();
    m_free = PAGE_NUM; m_ptr = 0; m_gnt = '0; m_addr = '0;
    stg.delete(); alloc_q.delete(); pool.delete();
    for (int i = 0; i < PAGE_NUM; i++) pool.push_back(page_addr_t'((i + 5) % PAGE_NUM));
  endtask

  task automatic do_reset();
    req = '0; rel_v = 1'b0; rel_a = '0;
    rst_n = 1'b0;
    pa.alloc_req = '0; pa.rel_valid = 1'b0; pa.rel_addr = '0;
`ifdef PAGE_ALLOC_STAT_EN
    stat_clr = 1'b0;
`endif
    model_reset();
    pa.head_addr = pool[0];
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Apply inputs and predict this cycle's combinational outputs.
  task automatic eval();
    logic [PORT_NUM-1:0] elig;
    port_idx_t p;
    pa.alloc_req = req; pa.rel_valid = rel_v; pa.rel_addr = rel_a;
    pa.head_addr = pool[0];
    elig = req & ~m_gnt;
    e_win = -1;
    for (int k = 0; k < PORT_NUM; k++) begin
      p = port_idx_t'((m_ptr + k) % PORT_NUM);
      if (e_win < 0 && elig[p]) e_win = int'(p);
    end
    e_pop  = (e_win >= 0) && (m_free >= 2);
    e_push = (stg.size() != 0);
    e_tail = e_push ? stg[0] : '0;
    e_rdy  = (stg.size() < REL_DEPTH);
    #1;
  endtask

  // Clock edge: advance the model and the emulated free-page FIFO.
  task automatic tick();
    logic d_pop, d_push, acc;
    page_addr_t d_tail;
    d_pop = pa.pop_head; d_push = pa.push_tail; d_tail = pa.tail_addr;
    acc = rel_v && e_rdy;
    @(posedge clk);
    m_gnt = '0;
    if (e_pop) begin
      m_gnt[port_idx_t'(e_win)] = 1'b1;
      m_addr = pool[0];
      m_ptr  = (e_win + 1) % PORT_NUM;
      alloc_q.push_back(pool[0]);
    end
    if (e_push) void'(stg.pop_front());
    if (acc) stg.push_back(rel_a);
    m_free = m_free + (e_push ? 1 : 0) - (e_pop ? 1 : 0);
    if (d_pop && pool.size() != 0) void'(pool.pop_front());
    if (d_push) pool.push_back(d_tail);
    #1 pa.head_addr = pool[0];
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (pa.alloc_gnt !== '0) begin n_bad++; $display("FAIL rst_gnt: got %h want 0", pa.alloc_gnt); end
    n_cmp++; if (pa.alloc_addr !== '0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", pa.alloc_addr); end
    n_cmp++; if (pa.free_cnt !== 12'd2048) begin n_bad++; $display("FAIL rst_free: got %0d want 2048", pa.free_cnt); end
    n_cmp++; if (pa.rel_ready !== 1'b1) begin n_bad++; $display("FAIL rst_rdy: got %b want 1", pa.rel_ready); end
    n_cmp++; if (pa.pop_head !== 1'b0 || pa.push_tail !== 1'b0) begin n_bad++; $display("FAIL rst_pop_push: got %b%b want 00", pa.pop_head, pa.push_tail); end
    n_cmp++; if (pa.tail_addr !== '0) begin n_bad++; $display("FAIL rst_tail: got %h want 0", pa.tail_addr); end
    n_cmp++; if (pa.pool_low !== 1'b0) begin n_bad++; $display("FAIL rst_low: got %b want 0", pa.pool_low); end
  endtask

  task automatic test_single();
    req = 16'h0001; eval();
    n_cmp++; if (pa.pop_head !== 1'b1) begin n_bad++; $display("FAIL single_pop: got %b want 1", pa.pop_head); end
    tick(); req = '0;
    n_cmp++; if (pa.alloc_gnt !== 16'h0001) begin n_bad++; $display("FAIL single_gnt: got %h want 0001", pa.alloc_gnt); end
    n_cmp++; if (pa.alloc_addr !== 11'd5) begin n_bad++; $display("FAIL single_addr: got %0d want 5", pa.alloc_addr); end
    n_cmp++; if (pa.free_cnt !== 12'd2047) begin n_bad++; $display("FAIL single_free: got %0d want 2047", pa.free_cnt); end
    eval(); tick();
    n_cmp++; if (pa.alloc_gnt !== '0) begin n_bad++; $display("FAIL single_gnt_drop: got %h want 0", pa.alloc_gnt); end
  endtask

  task automatic test_round_robin();
    logic [PORT_NUM-1:0] want;
    do_reset();
    req = '1;
    for (int i = 0; i < PORT_NUM; i++) begin
      eval(); tick();
      want = '0; want[i] = 1'b1;
      n_cmp++; if (pa.alloc_gnt !== want) begin n_bad++; $display("FAIL rr_order[%0d]: got %h want %h", i, pa.alloc_gnt, want); end
      req = req & ~pa.alloc_gnt;
    end
    n_cmp++; if (pa.free_cnt !== 12'(PAGE_NUM - 16)) begin n_bad++; $display("FAIL rr_free: got %0d want %0d", pa.free_cnt, PAGE_NUM - 16); end
    eval(); tick();
    n_cmp++; if (pa.alloc_gnt !== '0) begin n_bad++; $display("FAIL rr_idle: got %h want 0", pa.alloc_gnt); end
  endtask

  task automatic test_drain();
    page_addr_t rp;
    req = '1;
    for (int c = 0; c < 3000 && m_free > 2; c++) begin eval(); tick(); end
    n_cmp++; if (pa.free_cnt !== 12'd2) begin n_bad++; $display("FAIL drain_reach2: got %0d want 2", pa.free_cnt); end
    eval();
    n_cmp++; if (pa.pop_head !== 1'b1) begin n_bad++; $display("FAIL drain_last_pop: got %b want 1", pa.pop_head); end
    tick();
    n_cmp++; if (pa.free_cnt !== 12'd1 || pa.pool_low !== 1'b1) begin n_bad++; $display("FAIL drain_low: got cnt %0d low %b want 1 1", pa.free_cnt, pa.pool_low); end
    eval();
    n_cmp++; if (pa.pop_head !== 1'b0) begin n_bad++; $display("FAIL drain_nopop: got %b want 0", pa.pop_head); end
    tick();
    n_cmp++; if (pa.alloc_gnt !== '0) begin n_bad++; $display("FAIL drain_nogrant: got %h want 0", pa.alloc_gnt); end
    rp = alloc_q.pop_front(); rel_v = 1'b1; rel_a = rp; eval();
    n_cmp++; if (pa.push_tail !== 1'b0 || pa.rel_ready !== 1'b1) begin n_bad++; $display("FAIL drain_rel_in: got push %b rdy %b want 0 1", pa.push_tail, pa.rel_ready); end
    tick(); rel_v = 1'b0; eval();
    n_cmp++; if (pa.push_tail !== 1'b1 || pa.tail_addr !== rp) begin n_bad++; $display("FAIL drain_push: got %b %0d want 1 %0d", pa.push_tail, pa.tail_addr, rp); end
    n_cmp++; if (pa.pop_head !== 1'b0) begin n_bad++; $display("FAIL drain_pop_at1: got %b want 0", pa.pop_head); end
    tick();
    n_cmp++; if (pa.free_cnt !== 12'd2) begin n_bad++; $display("FAIL drain_back2: got %0d want 2", pa.free_cnt); end
    eval();
    n_cmp++; if (pa.pop_head !== 1'b1) begin n_bad++; $display("FAIL drain_resume_pop: got %b want 1", pa.pop_head); end
    tick();
    n_cmp++; if (pa.alloc_gnt !== m_gnt || m_gnt == '0) begin n_bad++; $display("FAIL drain_resume_gnt: got %h want %h", pa.alloc_gnt, m_gnt); end
    req = '0;
  endtask

  task automatic test_simul();
    int k;
    k = 100 - m_free;
    rel_v = 1'b1;
    for (int i = 0; i < k; i++) begin
      rel_a = alloc_q.pop_front(); eval();
      n_cmp++; if (pa.rel_ready !== 1'b1) begin n_bad++; $display("FAIL fill_rdy[%0d]: got %b want 1", i, pa.rel_ready); end
      tick();
    end
    rel_v = 1'b0;
    for (int c = 0; c < 20 && stg.size() != 0; c++) begin eval(); tick(); end
    n_cmp++; if (pa.free_cnt !== 12'd100) begin n_bad++; $display("FAIL simul_at100: got %0d want 100", pa.free_cnt); end
    rel_v = 1'b1; rel_a = alloc_q.pop_front(); eval(); tick();
    rel_v = 1'b0; req = 16'h0010; eval();
    n_cmp++; if (pa.pop_head !== 1'b1 || pa.push_tail !== 1'b1) begin n_bad++; $display("FAIL simul_both: got pop %b push %b want 1 1", pa.pop_head, pa.push_tail); end
    tick(); req = '0;
    n_cmp++; if (pa.free_cnt !== 12'd100) begin n_bad++; $display("FAIL simul_hold: got %0d want 100", pa.free_cnt); end
    n_cmp++; if (pa.alloc_gnt !== 16'h0010) begin n_bad++; $display("FAIL simul_gnt: got %h want 0010", pa.alloc_gnt); end
  endtask

  task automatic test_back_to_back();
    page_addr_t order[$];
    do_reset();
    req = '1;
    repeat (9) begin eval(); tick(); end
    req = '0;
    n_cmp++; if (pa.free_cnt !== 12'(PAGE_NUM - 9)) begin n_bad++; $display("FAIL b2b_start: got %0d want %0d", pa.free_cnt, PAGE_NUM - 9); end
    for (int i = 0; i <= 9; i++) begin
      rel_v = (i < 9);
      if (i < 9) begin rel_a = alloc_q.pop_front(); order.push_back(rel_a); end
      eval();
      n_cmp++; if (pa.rel_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy[%0d]: got %b want 1", i, pa.rel_ready); end
      if (i > 0) begin
        n_cmp++; if (pa.push_tail !== 1'b1 || pa.tail_addr !== order[i-1]) begin n_bad++; $display("FAIL b2b_tail[%0d]: got %b %0d want 1 %0d", i, pa.push_tail, pa.tail_addr, order[i-1]); end
      end
      tick();
    end
    n_cmp++; if (pa.free_cnt !== 12'(PAGE_NUM)) begin n_bad++; $display("FAIL b2b_end: got %0d want %0d", pa.free_cnt, PAGE_NUM); end
  endtask

  task automatic test_reset_mid();
    req = '1;
    eval(); tick(); eval(); tick();
    rel_v = 1'b1; rel_a = alloc_q.pop_front(); eval(); tick();
    eval();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pa.alloc_gnt !== '0 || pa.alloc_addr !== '0) begin n_bad++; $display("FAIL mid_gnt: got %h %0d want 0 0", pa.alloc_gnt, pa.alloc_addr); end
    n_cmp++; if (pa.free_cnt !== 12'd2048 || pa.pool_low !== 1'b0) begin n_bad++; $display("FAIL mid_free: got %0d %b want 2048 0", pa.free_cnt, pa.pool_low); end
    n_cmp++; if (pa.pop_head !== 1'b0 || pa.push_tail !== 1'b0 || pa.tail_addr !== '0) begin n_bad++; $display("FAIL mid_fifo: got %b %b %0d want 0 0 0", pa.pop_head, pa.push_tail, pa.tail_addr); end
    n_cmp++; if (pa.rel_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rdy: got %b want 1", pa.rel_ready); end
`ifdef PAGE_ALLOC_STAT_EN
    n_cmp++; if (min_free !== 12'd2048) begin n_bad++; $display("FAIL mid_min_free: got %0d want 2048", min_free); end
`endif
    do_reset();
    req = 16'h8000; eval(); tick(); req = '0;
    n_cmp++; if (pa.alloc_gnt !== 16'h8000 || pa.alloc_addr !== 11'd5) begin n_bad++; $display("FAIL mid_after: got %h %0d want 8000 5", pa.alloc_gnt, pa.alloc_addr); end
  endtask

  task automatic test_random();
    int j;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req = PORT_NUM'($urandom) & PORT_NUM'($urandom);
      rel_v = (alloc_q.size() != 0) && ($urandom_range(0, 2) != 0);
      if (rel_v) begin
        j = $urandom_range(0, alloc_q.size() - 1);
        rel_a = alloc_q[j]; alloc_q.delete(j);
      end else rel_a = page_addr_t'($urandom);
      eval();
      n_cmp++; if (pa.pop_head !== e_pop || pa.push_tail !== e_push || pa.rel_ready !== e_rdy) begin n_bad++; $display("FAIL rnd_ctl[%0d]: got pop%b push%b rdy%b want %b %b %b", c, pa.pop_head, pa.push_tail, pa.rel_ready, e_pop, e_push, e_rdy); end
      n_cmp++; if (pa.tail_addr !== e_tail) begin n_bad++; $display("FAIL rnd_tail[%0d]: got %0d want %0d", c, pa.tail_addr, e_tail); end
      tick();
      n_cmp++; if (pa.alloc_gnt !== m_gnt || (m_gnt != '0 && pa.alloc_addr !== m_addr)) begin n_bad++; $display("FAIL rnd_gnt[%0d]: got %h %0d want %h %0d", c, pa.alloc_gnt, pa.alloc_addr, m_gnt, m_addr); end
      n_cmp++; if (pa.free_cnt !== page_cnt_t'(m_free) || pa.pool_low !== (m_free < 2)) begin n_bad++; $display("FAIL rnd_free[%0d]: got %0d want %0d", c, pa.free_cnt, m_free); end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_drain();
    test_simul();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
